net_layer_seq: RTL and testbench

Programmable network-level sequencer, the table-driven successor to the fixed 14-layer MobileNet controller. A host-loaded layer table sets each layer's type, output channels and stride, and a host register sets the layer count. The block runs an output-tile iterator for each layer and dispatches every tile to one compute engine over a start/busy/done handshake. It also swaps ping-pong feature-map bases between layers and supports a clean abort.

---
 rtl/net_layer_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_net_layer_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_layer_seq.sv
// Table-driven network sequencer: walks a host-loaded layer table, tiles each layer's output
// and dispatches tiles to one engine. Define NET_SEQ_PERF_EN to add the per-layer cycle counter.
module net_layer_seq #(
    parameter int DIM_W      = 16,
    parameter int ADDR_W     = 32,
    parameter int MAX_LAYERS = 32,
    parameter int TILE_H     = 16,
    parameter int TILE_W     = 16,
    parameter int KERNEL     = 3,
    parameter int PAD        = 1,
    localparam int AW        = $clog2(MAX_LAYERS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tbl_we,
    input  logic [AW-1:0]           tbl_addr,
    input  logic [1:0]              tbl_type,
    input  logic [DIM_W-1:0]        tbl_out_c,
    input  logic                    tbl_stride2,
    input  logic [AW:0]             cfg_num_layers,
    input  logic [DIM_W-1:0]        cfg_in_h,
    input  logic [DIM_W-1:0]        cfg_in_w,
    input  logic [DIM_W-1:0]        cfg_in_c,
    input  logic [ADDR_W-1:0]       cfg_fm_base0,
    input  logic [ADDR_W-1:0]       cfg_fm_base1,
    input  logic [ADDR_W-1:0]       cfg_scratch_base,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [DIM_W-1:0]        layer_idx,
    output logic [1:0]              layer_type,
    output logic [DIM_W-1:0]        cur_in_h,
    output logic [DIM_W-1:0]        cur_in_w,
    output logic [DIM_W-1:0]        cur_in_c,
    output logic [DIM_W-1:0]        cur_out_h,
    output logic [DIM_W-1:0]        cur_out_w,
    output logic [DIM_W-1:0]        cur_out_c,
    output logic [DIM_W-1:0]        cur_stride,
    output logic [DIM_W-1:0]        tile_out_row,
    output logic [DIM_W-1:0]        tile_out_col,
    output logic [DIM_W-1:0]        tile_out_h,
    output logic [DIM_W-1:0]        tile_out_w,
    output logic signed [DIM_W:0]   tile_in_row,
    output logic signed [DIM_W:0]   tile_in_col,
    output logic [DIM_W-1:0]        tile_in_h,
    output logic [DIM_W-1:0]        tile_in_w,
    output logic [ADDR_W-1:0]       in_base_addr,
    output logic [ADDR_W-1:0]       out_base_addr,
    output logic [ADDR_W-1:0]       scratch_base_addr,
    output logic                    eng_start,
    output logic [1:0]              eng_mode,
    input  logic                    eng_busy,
    input  logic                    eng_done
`ifdef NET_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_layer_cycles,
    output logic                    perf_layer_valid
`endif
);
    localparam int XW = DIM_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CFG, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_DRAIN} state_t;
    typedef struct packed {
        logic [1:0]       ty;
        logic [DIM_W-1:0] out_c;
        logic             s2;
    } ent_t;
    typedef struct packed {
        logic [DIM_W-1:0]     osz;
        logic signed [XW-1:0] org;
        logic [DIM_W-1:0]     isz;
    } win_t;

    state_t           state, state_n;
    ent_t             tbl [MAX_LAYERS];
    ent_t             ent;
    logic             base_sel, abort_exit, col_wrap, row_last, last_tile, w_s2;
    logic [AW:0]      num_lat;
    logic [DIM_W-1:0] cfg_oh, cfg_ow, nxt_row, nxt_col, w_row, w_col, w_oh, w_ow;
    win_t             win_h, win_w;

    function automatic logic [DIM_W-1:0] out_dim(input logic [DIM_W-1:0] d, input logic s2);
        logic [XW-1:0] t;
        t = {1'b0, d} + XW'(2 * PAD) - XW'(KERNEL);
        return DIM_W'((t >> s2) + XW'(1));
    endfunction

    // Stride is 1 or 2, so every multiply by stride is a shift by s2.
    function automatic win_t win(input logic [DIM_W-1:0] pos, input logic [DIM_W-1:0] odim,
                                 input logic s2, input int tile);
        win_t          w;
        logic [XW-1:0] rem;
        rem   = {1'b0, odim} - {1'b0, pos};
        w.osz = (rem > XW'(tile)) ? DIM_W'(tile) : rem[DIM_W-1:0];
        w.org = $signed(({1'b0, pos} << s2) - XW'(PAD));
        w.isz = DIM_W'((({1'b0, w.osz} - XW'(1)) << s2) + XW'(KERNEL));
        return w;
    endfunction

    assign busy      = (state != S_IDLE);
    assign eng_mode  = layer_type;
    assign cfg_oh    = out_dim(cur_in_h, ent.s2);
    assign cfg_ow    = out_dim(cur_in_w, ent.s2);
    assign col_wrap  = ({1'b0, tile_out_col} + XW'(TILE_W)) >= {1'b0, cur_out_w};
    assign row_last  = ({1'b0, tile_out_row} + XW'(TILE_H)) >= {1'b0, cur_out_h};
    assign last_tile = col_wrap && row_last;
    assign nxt_col   = col_wrap ? '0 : tile_out_col + DIM_W'(TILE_W);
    assign nxt_row   = col_wrap ? tile_out_row + DIM_W'(TILE_H) : tile_out_row;

    // In CFG the first window is built from the dims being latched that same cycle.
    assign w_row = (state == S_CFG) ? '0 : nxt_row;
    assign w_col = (state == S_CFG) ? '0 : nxt_col;
    assign w_oh  = (state == S_CFG) ? cfg_oh : cur_out_h;
    assign w_ow  = (state == S_CFG) ? cfg_ow : cur_out_w;
    assign w_s2  = (state == S_CFG) ? ent.s2 : cur_stride[1];
    assign win_h = win(w_row, w_oh, w_s2, TILE_H);
    assign win_w = win(w_col, w_ow, w_s2, TILE_W);

    always_ff @(posedge clk) begin
        if (tbl_we && !busy) tbl[tbl_addr] <= '{ty: tbl_type, out_c: tbl_out_c, s2: tbl_stride2};
        if (state == S_LOAD) ent <= tbl[layer_idx[AW-1:0]];
    end

    always_comb begin
        state_n    = state;
        eng_start  = 1'b0;
        abort_exit = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = (cfg_num_layers == '0) ? S_DONE : S_LOAD;
            S_LOAD:  state_n = S_CFG;
            S_CFG:   state_n = S_ISSUE;
            S_ISSUE: if (!eng_busy) begin
                eng_start = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT:  if (eng_done) state_n = last_tile ? S_NEXT : S_ISSUE;
            S_NEXT:  state_n = (layer_idx == DIM_W'(num_lat) - DIM_W'(1)) ? S_DONE : S_LOAD;
            S_DONE:  state_n = S_IDLE;
            S_DRAIN: if (eng_done) begin
                state_n    = S_IDLE;
                abort_exit = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // An in-flight tile must finish before we report the abort.
        if (abort && busy && state != S_DRAIN) begin
            eng_start = 1'b0;
            if (state == S_WAIT && !eng_done) begin
                state_n = S_DRAIN;
            end else begin
                state_n    = S_IDLE;
                abort_exit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            base_sel <= 1'b0;
            num_lat <= '0;
            done <= 1'b0;
            aborted <= 1'b0;
            layer_idx <= '0;
            layer_type <= '0;
            cur_in_h <= '0;
            cur_in_w <= '0;
            cur_in_c <= '0;
            cur_out_h <= '0;
            cur_out_w <= '0;
            cur_out_c <= '0;
            cur_stride <= '0;
            tile_out_row <= '0;
            tile_out_col <= '0;
            tile_out_h <= '0;
            tile_out_w <= '0;
            tile_in_row <= '0;
            tile_in_col <= '0;
            tile_in_h <= '0;
            tile_in_w <= '0;
            in_base_addr <= '0;
            out_base_addr <= '0;
            scratch_base_addr <= '0;
        end else begin
            state             <= state_n;
            done              <= (state == S_DONE) && !abort;
            aborted           <= abort_exit;
            in_base_addr      <= base_sel ? cfg_fm_base1 : cfg_fm_base0;
            out_base_addr     <= base_sel ? cfg_fm_base0 : cfg_fm_base1;
            scratch_base_addr <= cfg_scratch_base;
            case (state)
                S_IDLE: if (start && cfg_num_layers != '0) begin
                    cur_in_h  <= cfg_in_h;
                    cur_in_w  <= cfg_in_w;
                    cur_in_c  <= cfg_in_c;
                    layer_idx <= '0;
                    base_sel  <= 1'b0;
                    num_lat   <= cfg_num_layers;
                end
                S_CFG: begin
                    layer_type   <= (ent.ty == 2'd3) ? 2'd1 : ent.ty;
                    cur_out_c    <= ent.out_c;
                    cur_stride   <= ent.s2 ? DIM_W'(2) : DIM_W'(1);
                    cur_out_h    <= cfg_oh;
                    cur_out_w    <= cfg_ow;
                    tile_out_row <= '0;
                    tile_out_col <= '0;
                end
                S_WAIT: if (eng_done && !last_tile) begin
                    tile_out_row <= nxt_row;
                    tile_out_col <= nxt_col;
                end
                S_NEXT: begin
                    cur_in_h <= cur_out_h;
                    cur_in_w <= cur_out_w;
                    cur_in_c <= cur_out_c;
                    base_sel <= ~base_sel;
                    if (state_n == S_LOAD) layer_idx <= layer_idx + DIM_W'(1);
                end
                default: ;
            endcase
            if (state_n == S_ISSUE && state != S_ISSUE) begin
                tile_out_h  <= win_h.osz;
                tile_out_w  <= win_w.osz;
                tile_in_row <= win_h.org;
                tile_in_col <= win_w.org;
                tile_in_h   <= win_h.isz;
                tile_in_w   <= win_w.isz;
            end
        end
    end

`ifdef NET_SEQ_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt          <= '0;
            perf_layer_cycles <= '0;
            perf_layer_valid  <= 1'b0;
        end else begin
            perf_layer_valid <= 1'b0;
            if (state == S_LOAD) perf_cnt <= '0;
            else if (busy)       perf_cnt <= perf_cnt + 32'd1;
            // The reported count includes the NEXT cycle itself.
            if (state == S_NEXT) begin
                perf_layer_cycles <= perf_cnt + 32'd1;
                perf_layer_valid  <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_net_layer_seq.sv
// Bench for net_layer_seq: table of network runs with a tile scoreboard, plus abort/stall/corner sequences.
`timescale 1ns/1ps
module tb_net_layer_seq;
    localparam int PAD = 1, KERNEL = 3, TILE = 16;
    localparam logic [31:0] B0 = 32'h1000_0000, B1 = 32'h2000_0000, BS = 32'h3000_0000;

    logic clk = 1'b0, rst_n = 1'b0;
    logic tbl_we = 0, tbl_stride2 = 0, start = 0, abort = 0, eng_busy, eng_done;
    logic [4:0] tbl_addr = '0;
    logic [1:0] tbl_type = '0;
    logic [15:0] tbl_out_c = '0, cfg_in_h = 16'd7, cfg_in_w = 16'd7, cfg_in_c = 16'd7;
    logic [5:0] cfg_num_layers = 6'd1;
    logic busy, done, aborted, eng_start;
    logic [1:0] layer_type, eng_mode;
    logic [15:0] layer_idx, cur_in_h, cur_in_w, cur_in_c, cur_out_h, cur_out_w, cur_out_c, cur_stride;
    logic [15:0] tile_out_row, tile_out_col, tile_out_h, tile_out_w, tile_in_h, tile_in_w;
    logic signed [16:0] tile_in_row, tile_in_col;
    logic [31:0] in_base_addr, out_base_addr, scratch_base_addr;
`ifdef NET_SEQ_PERF_EN
    logic [31:0] perf_layer_cycles;
    logic perf_layer_valid;
`endif

    always #5 clk = ~clk;

    net_layer_seq dut (
        .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_type(tbl_type),
        .tbl_out_c(tbl_out_c), .tbl_stride2(tbl_stride2), .cfg_num_layers(cfg_num_layers),
        .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_in_c(cfg_in_c),
        .cfg_fm_base0(B0), .cfg_fm_base1(B1), .cfg_scratch_base(BS),
        .start(start), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .layer_idx(layer_idx), .layer_type(layer_type),
        .cur_in_h(cur_in_h), .cur_in_w(cur_in_w), .cur_in_c(cur_in_c),
        .cur_out_h(cur_out_h), .cur_out_w(cur_out_w), .cur_out_c(cur_out_c), .cur_stride(cur_stride),
        .tile_out_row(tile_out_row), .tile_out_col(tile_out_col), .tile_out_h(tile_out_h),
        .tile_out_w(tile_out_w), .tile_in_row(tile_in_row), .tile_in_col(tile_in_col),
        .tile_in_h(tile_in_h), .tile_in_w(tile_in_w),
        .in_base_addr(in_base_addr), .out_base_addr(out_base_addr), .scratch_base_addr(scratch_base_addr),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_done(eng_done)
`ifdef NET_SEQ_PERF_EN
        , .perf_layer_cycles(perf_layer_cycles), .perf_layer_valid(perf_layer_valid)
`endif
    );

    typedef struct packed {
        logic [7:0]  layer;
        logic [1:0]  mode;
        logic [15:0] orow, ocol, oh, ow;
        logic [16:0] irow, icol;
        logic [15:0] ih, iw;
        logic [31:0] ib, ob;
    } tile_t;
    tile_t exp_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int n_start = 0, n_done = 0, n_abort = 0, done_cyc = -1, abort_cyc = -1, edone_cyc = -1;
    int perf_n = 0;
    logic [31:0] perf_last = '0;
    int eng_lat = 5, eng_rem = 0;
    logic eng_hold = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model: done pulses eng_lat cycles after the launch cycle.
    initial begin : engine
        logic st;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            st = eng_start;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (eng_rem > 0) begin
                eng_rem--;
                if (eng_rem == 0) eng_done = 1'b1;
            end
            if (st) eng_rem = eng_lat - 1;
            eng_busy = eng_hold || (eng_rem > 0);
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        tile_t act;
        if (rst_n) begin
            if (eng_start) begin
                n_start++;
                chk("start_vs_busy", eng_busy, 1'b0);
                act.layer = layer_idx[7:0];  act.mode = eng_mode;
                act.orow = tile_out_row;     act.ocol = tile_out_col;
                act.oh = tile_out_h;         act.ow = tile_out_w;
                act.irow = tile_in_row;      act.icol = tile_in_col;
                act.ih = tile_in_h;          act.iw = tile_in_w;
                act.ib = in_base_addr;       act.ob = out_base_addr;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got tile %0h expected no launch", act);
                end else begin
                    chk("tile", act, exp_q.pop_front());
                end
            end
            if (eng_done) edone_cyc = cyc;
            if (done) begin n_done++; done_cyc = cyc; end
            if (aborted) begin n_abort++; abort_cyc = cyc; end
`ifdef NET_SEQ_PERF_EN
            if (perf_layer_valid) begin perf_n++; perf_last = perf_layer_cycles; end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [1:0] t, input logic [15:0] oc, input logic s);
        tick();
        tbl_we = 1'b1; tbl_addr = 5'(a); tbl_type = t; tbl_out_c = oc; tbl_stride2 = s;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic pulse_start(output int s_cyc);
        tick();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int a0, input int budget, input string name);
        int i = 0;
        while (n_done == d0 && n_abort == a0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done/aborted in %0d cycles expected one", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    // Reference tile list, written with plain integer division.
    task automatic push_run(input int nl, input int ih, input int iw,
                            input logic [2:0][1:0] ty, input logic [2:0] s2);
        int h, w, oh, ow, s;
        tile_t t;
        h = ih;
        w = iw;
        for (int l = 0; l < nl; l++) begin
            s  = s2[l] ? 2 : 1;
            oh = (h + 2 * PAD - KERNEL) / s + 1;
            ow = (w + 2 * PAD - KERNEL) / s + 1;
            for (int r = 0; r < oh; r += TILE)
                for (int c = 0; c < ow; c += TILE) begin
                    t.layer = 8'(l);
                    t.mode  = (ty[l] == 2'd3) ? 2'd1 : ty[l];
                    t.orow  = 16'(r);
                    t.ocol  = 16'(c);
                    t.oh    = 16'((oh - r < TILE) ? oh - r : TILE);
                    t.ow    = 16'((ow - c < TILE) ? ow - c : TILE);
                    t.irow  = 17'(r * s - PAD);
                    t.icol  = 17'(c * s - PAD);
                    t.ih    = 16'((int'(t.oh) - 1) * s + KERNEL);
                    t.iw    = 16'((int'(t.ow) - 1) * s + KERNEL);
                    t.ib    = (l % 2) ? B1 : B0;
                    t.ob    = (l % 2) ? B0 : B1;
                    exp_q.push_back(t);
                end
            h = oh;
            w = ow;
        end
    endtask

    typedef struct {
        int nl, ih, iw, ic, lat;
        logic [2:0][1:0] ty;
        logic [2:0] s2;
        int starts, fh, fw;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int s0, d0, a0, p0, sc, ac;
        vecs[0] = '{1, 32, 32, 3, 5, {2'd0, 2'd0, 2'd0}, 3'b001, 1, 16, 16};
        vecs[1] = '{2, 64, 48, 8, 3, {2'd0, 2'd2, 2'd1}, 3'b001, 8, 32, 24};
        vecs[2] = '{3, 20, 10, 4, 2, {2'd1, 2'd2, 2'd3}, 3'b110, 4, 5, 3};
        vecs[3] = '{1, 1, 1, 1, 2, {2'd0, 2'd0, 2'd2}, 3'b001, 1, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_layer_idx", layer_idx, 16'd0);
        chk("rst_cur_out_h", cur_out_h, 16'd0);
        chk("rst_tile_in_row", tile_in_row, 17'd0);
        chk("rst_in_base", in_base_addr, 32'd0);
        tick();
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            for (int l = 0; l < vecs[v].nl; l++)
                load(l, vecs[v].ty[l], 16'(16 * (l + 1) + v), vecs[v].s2[l]);
            cfg_num_layers = 6'(vecs[v].nl);
            cfg_in_h = 16'(vecs[v].ih);
            cfg_in_w = 16'(vecs[v].iw);
            cfg_in_c = 16'(vecs[v].ic);
            eng_lat  = vecs[v].lat;
            push_run(vecs[v].nl, vecs[v].ih, vecs[v].iw, vecs[v].ty, vecs[v].s2);
            s0 = n_start; d0 = n_done; a0 = n_abort; p0 = perf_n;
            pulse_start(sc);
            wait_end(d0, a0, 2000, $sformatf("v%0d", v));
            chk($sformatf("v%0d_starts", v), n_start - s0, vecs[v].starts);
            chk($sformatf("v%0d_done_cnt", v), n_done - d0, 1);
            chk($sformatf("v%0d_abort_cnt", v), n_abort - a0, 0);
            chk($sformatf("v%0d_q_left", v), exp_q.size(), 0);
            chk($sformatf("v%0d_out_h", v), cur_out_h, 16'(vecs[v].fh));
            chk($sformatf("v%0d_out_w", v), cur_out_w, 16'(vecs[v].fw));
            chk($sformatf("v%0d_out_c", v), cur_out_c, 16'(16 * vecs[v].nl + v));
            chk($sformatf("v%0d_in_h", v), cur_in_h, 16'(vecs[v].fh));
            chk($sformatf("v%0d_in_c", v), cur_in_c, 16'(16 * vecs[v].nl + v));
            chk($sformatf("v%0d_layer_idx", v), layer_idx, 16'(vecs[v].nl - 1));
            chk($sformatf("v%0d_busy", v), busy, 1'b0);
`ifdef NET_SEQ_PERF_EN
            chk($sformatf("v%0d_perf_pulses", v), perf_n - p0, vecs[v].nl);
            if (v == 0) chk("perf_count_ge8", perf_last >= 32'd8, 1'b1);
`endif
            exp_q.delete();
        end
        chk("scratch_base", scratch_base_addr, BS);

        // Abort while a tile is in flight: wait for eng_done, then report.
        load(0, 2'd0, 16'd32, 1'b1);
        cfg_num_layers = 6'd1; cfg_in_h = 16'd32; cfg_in_w = 16'd32; cfg_in_c = 16'd3;
        eng_lat = 10;
        push_run(1, 32, 32, {2'd0, 2'd0, 2'd0}, 3'b001);
        s0 = n_start; d0 = n_done; a0 = n_abort;
        pulse_start(sc);
        for (int i = 0; i < 20 && n_start == s0; i++) @(negedge clk);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("drain_busy", busy, 1'b1);
        wait_end(d0, a0, 100, "abort_wait");
        chk("abort_wait_cnt", n_abort - a0, 1);
        chk("abort_wait_no_done", n_done - d0, 0);
        chk("abort_after_eng_done", abort_cyc, edone_cyc + 1);
        chk("abort_wait_starts", n_start - s0, 1);
        chk("abort_wait_busy", busy, 1'b0);

        // Abort while stalled in ISSUE: no launch, aborted the next cycle.
        eng_lat = 5;
        eng_hold = 1'b1;
        s0 = n_start; d0 = n_done; a0 = n_abort;
        pulse_start(sc);
        repeat (5) tick();
        abort = 1'b1;
        ac = cyc;
        tick();
        abort = 1'b0;
        wait_end(d0, a0, 50, "abort_issue");
        chk("abort_issue_cyc", abort_cyc, ac + 1);
        chk("abort_issue_starts", n_start - s0, 0);
        chk("abort_issue_no_done", n_done - d0, 0);
        eng_hold = 1'b0;
        repeat (3) tick();

        // Engine busy stalls ISSUE; restart and table writes during the run are ignored.
        eng_hold = 1'b1;
        push_run(1, 32, 32, {2'd0, 2'd0, 2'd0}, 3'b001);
        s0 = n_start; d0 = n_done; a0 = n_abort;
        pulse_start(sc);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        load(0, 2'd2, 16'd99, 1'b0);
        repeat (6) tick();
        chk("hold_no_start", n_start - s0, 0);
        eng_hold = 1'b0;
        wait_end(d0, a0, 100, "hold");
        chk("hold_starts", n_start - s0, 1);
        chk("hold_done_cnt", n_done - d0, 1);

        // Zero-layer run: done two cycles after start, no launch.
        cfg_num_layers = 6'd0;
        s0 = n_start; d0 = n_done; a0 = n_abort;
        pulse_start(sc);
        wait_end(d0, a0, 20, "zero");
        chk("zero_done_cyc", done_cyc, sc + 2);
        chk("zero_starts", n_start - s0, 0);

        // Table readback: the in-run write must not have landed.
        cfg_num_layers = 6'd1;
        push_run(1, 32, 32, {2'd0, 2'd0, 2'd0}, 3'b001);
        s0 = n_start; d0 = n_done; a0 = n_abort;
        pulse_start(sc);
        wait_end(d0, a0, 200, "readback");
        chk("readback_starts", n_start - s0, 1);
        chk("readback_out_c", cur_out_c, 16'd32);
        chk("readback_out_h", cur_out_h, 16'd16);
        chk("readback_q_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
